// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: CPU and debug requesters share one Pmmu port with fixed-length strobed cycles.
// Optional debug port and round-robin arbitration are enabled by defining DBG_PORT_EN.
module mem_port_arbiter #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  cpu_rd_i,
   input  logic                  cpu_wr_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
   output logic                  cpu_busy_o,
   output logic [DATA_WIDTH-1:0] cpu_rdata_o,
   input  logic                  dbg_req_i,
   input  logic                  dbg_we_i,
   input  logic [ADDR_WIDTH-1:0] dbg_addr_i,
   input  logic [DATA_WIDTH-1:0] dbg_wdata_i,
   output logic                  dbg_done_o,
   output logic [DATA_WIDTH-1:0] dbg_rdata_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic                  mem_rd_o,
   output logic                  mem_wr_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_e;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);
   localparam logic       OWN_CPU   = 1'b0;
   localparam logic       OWN_DBG   = 1'b1;

   state_e                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic                  rd_n_q, rd_n_d;
   logic                  wr_n_q, wr_n_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic                  cpu_req;
   logic                  dbg_req;
   logic                  sel_dbg;

   assign cpu_req = !cpu_rd_i || !cpu_wr_i;

`ifdef DBG_PORT_EN
   logic                  owner_q, owner_d;
   logic                  last_owner_q, last_owner_d;
   logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;

   assign dbg_req = dbg_req_i;
   // On a tie the requester that was not served last wins.
   assign sel_dbg = dbg_req && (!cpu_req || (last_owner_q == OWN_CPU));

   assign cpu_busy_o  = cpu_req && !((state_q == ST_DONE) && (owner_q == OWN_CPU));
   assign dbg_done_o  = (state_q == ST_DONE) && (owner_q == OWN_DBG);
   assign dbg_rdata_o = dbg_rdata_q;
`else
   logic unused_dbg_req;

   assign unused_dbg_req = dbg_req_i;
   assign dbg_req        = 1'b0;
   assign sel_dbg        = 1'b0;

   assign cpu_busy_o  = cpu_req && (state_q != ST_DONE);
   assign dbg_done_o  = 1'b0;
   assign dbg_rdata_o = '0;
`endif

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      we_d        = we_q;
      rd_n_d      = 1'b1;
      wr_n_d      = 1'b1;
      cpu_rdata_d = cpu_rdata_q;
`ifdef DBG_PORT_EN
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      dbg_rdata_d  = dbg_rdata_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cpu_req || dbg_req) begin
               state_d = ST_ACCESS;
               cnt_d   = WAIT_INIT;
               if (sel_dbg) begin
                  addr_d  = dbg_addr_i;
                  wdata_d = dbg_wdata_i;
                  we_d    = dbg_we_i;
               end else begin
                  addr_d  = cpu_addr_i;
                  wdata_d = cpu_wdata_i;
                  // Both strobes low resolves to a write.
                  we_d    = !cpu_wr_i;
               end
               // Strobes are registered, so they are set up on the entry edge.
               rd_n_d = we_d;
               wr_n_d = !we_d;
`ifdef DBG_PORT_EN
               owner_d = sel_dbg ? OWN_DBG : OWN_CPU;
`endif
            end
         end
         ST_ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_DONE;
               if (!we_q) begin
`ifdef DBG_PORT_EN
                  if (owner_q == OWN_DBG) dbg_rdata_d = mem_rdata_i;
                  else                    cpu_rdata_d = mem_rdata_i;
`else
                  cpu_rdata_d = mem_rdata_i;
`endif
               end
            end else begin
               cnt_d  = cnt_q - 4'd1;
               rd_n_d = we_q;
               wr_n_d = !we_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
`ifdef DBG_PORT_EN
            last_owner_d = owner_q;
`endif
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         cpu_rdata_q <= '0;
`ifdef DBG_PORT_EN
         owner_q      <= OWN_CPU;
         last_owner_q <= OWN_DBG;
         dbg_rdata_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         cpu_rdata_q <= cpu_rdata_d;
`ifdef DBG_PORT_EN
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         dbg_rdata_q  <= dbg_rdata_d;
`endif
      end
   end

   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign mem_rd_o    = rd_n_q;
   assign mem_wr_o    = wr_n_q;
   assign cpu_rdata_o = cpu_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level reference model.
// Debug-port arbitration checks are compiled in when DBG_PORT_EN is defined.
module tb_mem_port_arbiter;

   localparam int W  = 2;
   localparam int DW = 32;
   localparam int AW = 32;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          cpu_rd_i, cpu_wr_i;
   logic [AW-1:0] cpu_addr_i;
   logic [DW-1:0] cpu_wdata_i;
   logic          cpu_busy_o;
   logic [DW-1:0] cpu_rdata_o;
   logic          dbg_req_i, dbg_we_i;
   logic [AW-1:0] dbg_addr_i;
   logic [DW-1:0] dbg_wdata_i;
   logic          dbg_done_o;
   logic [DW-1:0] dbg_rdata_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_rd_o, mem_wr_o;
   logic [DW-1:0] mem_rdata_i;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(W)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
      .cpu_wdata_i(cpu_wdata_i), .cpu_busy_o(cpu_busy_o), .cpu_rdata_o(cpu_rdata_o),
      .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
      .dbg_wdata_i(dbg_wdata_i), .dbg_done_o(dbg_done_o), .dbg_rdata_o(dbg_rdata_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rd_o(mem_rd_o),
      .mem_wr_o(mem_wr_o), .mem_rdata_i(mem_rdata_i)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One isolated CPU access. The model: busy high in cycles 0..W, the selected strobe
   // low in cycles 1..W carrying the request's address/data, read data valid in cycle W+1.
   task automatic cpu_txn(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd);
      logic is_wr;
      is_wr = (kind != 0);
      @(negedge clk_i);
      cpu_rd_i    = (kind == 1);
      cpu_wr_i    = (kind == 0);
      cpu_addr_i  = a;
      cpu_wdata_i = wd;
      mem_rdata_i = $urandom;
      #1;
      check("busy_c0", cpu_busy_o, 1);
      check("rd_c0", mem_rd_o, 1);
      for (int c = 1; c <= W; c++) begin
         @(negedge clk_i);
         check("busy_acc", cpu_busy_o, 1);
         check("rd_acc", mem_rd_o, is_wr);
         check("wr_acc", mem_wr_o, !is_wr);
         check("addr_acc", mem_addr_o, a);
         if (is_wr) check("wdata_acc", mem_wdata_o, wd);
         check("dbg_done_acc", dbg_done_o, 0);
         mem_rdata_i = (c == W) ? rd : DW'($urandom);
      end
      @(negedge clk_i);
      check("busy_done", cpu_busy_o, 0);
      check("rd_done", mem_rd_o, 1);
      check("wr_done", mem_wr_o, 1);
      check("dbg_done_cpu", dbg_done_o, 0);
      if (!is_wr) check("cpu_rdata", cpu_rdata_o, rd);
      cpu_rd_i    = 1'b1;
      cpu_wr_i    = 1'b1;
      mem_rdata_i = $urandom;
      @(negedge clk_i);
      check("busy_idle", cpu_busy_o, 0);
      check("rd_idle", mem_rd_o, 1);
      check("wr_idle", mem_wr_o, 1);
      if (!is_wr) check("cpu_rdata_hold", cpu_rdata_o, rd);
      $display("txn kind=%0d addr=0x%08h wdata=0x%08h rdata=0x%08h", kind, a, wd, rd);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      reset_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      reset_i = 1'b1;
   endtask

`ifdef DBG_PORT_EN
   // Both requesters held continuously; the model grants to whoever was not served last,
   // starting with the CPU after reset.
   task automatic arb_run(input int n_acc);
      logic          last_dbg;
      logic          exp_dbg;
      logic [AW-1:0] ca, da;
      logic [DW-1:0] rd;
      int            strobe_cycles;
      bit            seen;
      int            pulses;
      last_dbg = 1'b1;
      pulses   = 0;
      ca = {$urandom} & 32'h7FFF_FFF0;
      da = ca | 32'h8000_0000;
      @(negedge clk_i);
      cpu_rd_i = 1'b0; cpu_wr_i = 1'b1; cpu_addr_i = ca;
      dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = da;
      for (int k = 0; k < n_acc; k++) begin
         exp_dbg = !last_dbg;
         rd = $urandom;
         mem_rdata_i = rd;
         seen = 0;
         for (int t = 0; t < 2 * W + 6 && !seen; t++) begin
            @(negedge clk_i);
            if (mem_rd_o == 1'b0) seen = 1;
            else check("arb_busy_wait", cpu_busy_o, 1);
            if (dbg_done_o) pulses++;
         end
         check("arb_strobe_seen", seen, 1);
         check("arb_owner_addr", mem_addr_o, exp_dbg ? da : ca);
         strobe_cycles = 0;
         while (mem_rd_o == 1'b0 && strobe_cycles < 20) begin
            check("arb_busy_acc", cpu_busy_o, 1);
            strobe_cycles++;
            @(negedge clk_i);
         end
         check("arb_strobe_len", strobe_cycles, W);
         check("arb_dbg_done", dbg_done_o, exp_dbg);
         check("arb_busy_done", cpu_busy_o, exp_dbg);
         if (dbg_done_o) pulses++;
         if (exp_dbg) check("arb_dbg_rdata", dbg_rdata_o, rd);
         else         check("arb_cpu_rdata", cpu_rdata_o, rd);
         $display("arb access %0d owner=%s", k, exp_dbg ? "DBG" : "CPU");
         last_dbg = exp_dbg;
      end
      check("arb_dbg_pulses", pulses, n_acc / 2);
      cpu_rd_i = 1'b1;
      dbg_req_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
   endtask
`endif

   initial begin
      reset_i = 1'b0;
      cpu_rd_i = 1'b1; cpu_wr_i = 1'b1; cpu_addr_i = '0; cpu_wdata_i = '0;
      dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = '0; dbg_wdata_i = '0;
      mem_rdata_i = '0;
      @(negedge clk_i);
      @(negedge clk_i);
      check("rst_rd", mem_rd_o, 1);
      check("rst_wr", mem_wr_o, 1);
      check("rst_addr", mem_addr_o, 0);
      check("rst_wdata", mem_wdata_o, 0);
      check("rst_cpu_rdata", cpu_rdata_o, 0);
      check("rst_dbg_rdata", dbg_rdata_o, 0);
      check("rst_dbg_done", dbg_done_o, 0);
      check("rst_busy", cpu_busy_o, 0);
      reset_i = 1'b1;

`ifdef DBG_PORT_EN
      arb_run(4);
      do_reset();
`else
      // Debug requests must be ignored entirely.
      dbg_req_i = 1'b1;
`endif

      cpu_txn(0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF);
      cpu_txn(2, 32'h0000_0100, 32'h1234_5678, 32'h0);
      for (int i = 0; i < 24; i++) begin
         dbg_we_i    = 1'($urandom);
         dbg_addr_i  = $urandom;
         dbg_wdata_i = $urandom;
         cpu_txn(int'($urandom_range(0, 2)), $urandom, $urandom, $urandom);
      end
      check("dbg_rdata_quiet", dbg_rdata_o, 0);

      // Asynchronous reset in the middle of a read access.
      @(negedge clk_i);
      cpu_rd_i = 1'b0; cpu_addr_i = 32'h0000_0200;
      @(negedge clk_i);
      check("pre_rst_rd", mem_rd_o, 0);
      #2 reset_i = 1'b0;
      #1;
      check("async_rst_rd", mem_rd_o, 1);
      check("async_rst_addr", mem_addr_o, 0);
      cpu_rd_i = 1'b1;
      @(negedge clk_i);
      reset_i = 1'b1;
      #1;
      check("post_rst_busy", cpu_busy_o, 0);
      check("post_rst_rd", mem_rd_o, 1);
      cpu_txn(0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
